id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline stage register. Next generation of the fixed 119-bit ID/EX latch.
- Adds a valid/ready handshake, a 2-entry skid buffer (registered in_ready), synchronous flush, load-use bubble insertion and a saturating stall counter.
- Sits between decode/register-read and the execute stage. The hazard unit drives flush and bubble.

Parameters:
- DATA_W, 32, width of each register operand and of the sign-extended immediate
- REG_ADDR_W, 5, width of the rs/rt/rd register specifiers
- WB_W, 2, write-back control field width
- M_W, 2, memory-stage control field width
- EX_W, 4, execute control field width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept (registered, equals !skid_valid)
- wb_in  in  WB_W  write-back controls
- m_in  in  M_W  memory controls
- ex_in  in  EX_W  execute controls
- data_r1_in  in  DATA_W  rs read data
- data_r2_in  in  DATA_W  rt read data
- sign_ext_in  in  DATA_W  sign-extended immediate
- rs_in, rt_in, rd_in  in  REG_ADDR_W each  register specifiers
- bubble  in  1  zero the control fields of the entry captured this cycle
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute consumes this cycle
- wb_out, m_out, ex_out, data_r1_out, data_r2_out, sign_ext_out, rs_out, rt_out, rd_out  out  match inputs  held entry
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready

Behaviour:
- Reset (synchronous, highest priority): all outputs zero, both entries invalid, in_ready=1 from the cycle after rst deasserts. Any handshake during a rst cycle is ignored.
- Transfer rules:
  - Accept when in_valid & in_ready.
  - Deliver when out_valid & out_ready.
- Latency: an accepted entry appears on the outputs the next cycle if the main register is empty or being drained. Otherwise it goes to the skid register.
- Main register update:
  - Skid valid and main drained: skid moves to main and skid clears.
  - Otherwise, main empty or drained and accept: input loads into main.
  - Accept while main held (out_valid & !out_ready): input loads into skid and in_ready drops next cycle.
- in_ready returns to 1 the cycle after the skid entry moves to main. Ordering is strictly FIFO, with no loss or duplication.
- Bubble: on an accepted entry with bubble=1, the wb/m/ex fields are stored as zero. The data fields and rs/rt/rd are stored as given, and valid is stored as 1. The resulting NOP still occupies a slot. bubble is ignored when no accept occurs.
- Flush (priority below rst):
  - Main and skid are invalidated, their control fields zeroed, and a same-cycle accept is consumed and discarded.
  - in_ready=1 next cycle.
  - Data fields retain old values.
- Output masking: wb_out/m_out/ex_out are forced to 0 whenever out_valid=0. Data and specifier outputs hold the last loaded value.
- Simultaneous events:
  - Flush with deliver: the delivery counts downstream, then the stage empties.
  - Bubble with flush: flush wins.
- stall_cnt: +1 each cycle with out_valid & !out_ready, saturating at 2^CNT_W-1. Cleared only by rst; flush does not clear it.

Decomposition:
- Shared package id_ex_pkg:
  - width localparams (defaults above)
  - PAYLOAD_W = WB_W+M_W+EX_W+3*DATA_W+3*REG_ADDR_W (119 at defaults)
  - CTRL_W = WB_W+M_W+EX_W
  - field order for packing: {wb, m, ex, r1, r2, sext, rt, rd, rs}
- Sub-module pipe_skid_buf:
  - generic W-bit 2-entry skid buffer with valid/ready, flush and registered in_ready
  - the top packs the payload, applies bubble masking before it, and applies output masking and the stall counter after it

Test Plan:
- Reset then stream 4 entries (data_r1 = 1, 2, 3, 4) with out_ready=1 → each appears 1 cycle after accept, in order; in_ready stays 1; stall_cnt=0.
- Hold out_ready=0 after entry A is in main; present B → B goes to skid, in_ready=0 next cycle. Raise out_ready → A then B delivered on consecutive cycles, in_ready=1 again. stall_cnt counts exactly the held cycles.
- Accept wb=2'b11, m=2'b10, ex=4'hF, rd=5'd9 with bubble=1 → out_valid=1, wb/m/ex outputs zero, rd_out=9.
- Main and skid both full; assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, control outputs 0. The flushed-cycle input never appears.
- Assert rst with both entries full → next cycle out_valid=0, all outputs 0, stall_cnt=0, in_ready=1.
- CNT_W=4, hold stall 20 cycles → stall_cnt saturates at 15 and stays there.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared widths and payload layout for the ID/EX stage register.
package id_ex_pkg;

  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefRegAddrW = 5;
  localparam int unsigned DefWbW      = 2;
  localparam int unsigned DefMW       = 2;
  localparam int unsigned DefExW      = 4;
  localparam int unsigned DefCntW     = 16;

  localparam int unsigned CTRL_W    = DefWbW + DefMW + DefExW;
  localparam int unsigned PAYLOAD_W = CTRL_W + 3 * DefDataW + 3 * DefRegAddrW;

  // Packed order is {wb, m, ex, r1, r2, sext, rt, rd, rs}.
  // The control fields sit in the top CTRL_W bits.
  function automatic int unsigned payload_w(int unsigned data_w, int unsigned reg_w,
                                            int unsigned ctrl_w);
    return ctrl_w + 3 * data_w + 3 * reg_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready, synchronous flush and registered in_ready.
// On flush the top ClrW bits of both entries are cleared and the rest are kept.
module pipe_skid_buf #(
  parameter int unsigned W    = 8,
  parameter int unsigned ClrW = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  localparam logic [W-1:0] KeepMask = {W{1'b1}} >> ClrW;

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept;
  logic         drained;

  // Next-state: flush, then skid refill, then direct load, then overflow into skid.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    accept       = in_valid_i & ~skid_valid_q;
    drained      = ~main_valid_q | out_ready_i;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = main_data_q & KeepMask;
      skid_data_d  = skid_data_q & KeepMask;
    end else if (skid_valid_q && drained) begin
      // in_ready is low while skid is full, so no accept can collide here.
      main_data_d  = skid_data_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (drained) begin
      main_valid_d = accept;
      if (accept) main_data_d = in_data_i;
    end else if (accept) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register: bubble masking, skid-buffered handshake, output
// control masking and a saturating stall counter.
module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned REG_ADDR_W = DefRegAddrW,
  parameter int unsigned WB_W       = DefWbW,
  parameter int unsigned M_W        = DefMW,
  parameter int unsigned EX_W       = DefExW,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WB_W-1:0]       wb_in,
  input  logic [M_W-1:0]        m_in,
  input  logic [EX_W-1:0]       ex_in,
  input  logic [DATA_W-1:0]     data_r1_in,
  input  logic [DATA_W-1:0]     data_r2_in,
  input  logic [DATA_W-1:0]     sign_ext_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  bubble,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WB_W-1:0]       wb_out,
  output logic [M_W-1:0]        m_out,
  output logic [EX_W-1:0]       ex_out,
  output logic [DATA_W-1:0]     data_r1_out,
  output logic [DATA_W-1:0]     data_r2_out,
  output logic [DATA_W-1:0]     sign_ext_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned CtrlW = WB_W + M_W + EX_W;
  localparam int unsigned PldW  = payload_w(DATA_W, REG_ADDR_W, CtrlW);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CtrlW-1:0] ctrl_in, ctrl_held;
  logic [PldW-1:0]  pld_in, pld_out;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A bubble turns the captured entry into a NOP; data and specifiers pass through.
  assign ctrl_in = bubble ? '0 : {wb_in, m_in, ex_in};
  assign pld_in  = {ctrl_in, data_r1_in, data_r2_in, sign_ext_in, rt_in, rd_in, rs_in};

  pipe_skid_buf #(
    .W    (PldW),
    .ClrW (CtrlW)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pld_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pld_out)
  );

  assign {ctrl_held, data_r1_out, data_r2_out, sign_ext_out, rt_out, rd_out, rs_out} = pld_out;

  // Control outputs read as zero whenever no valid entry is held.
  assign {wb_out, m_out, ex_out} = out_valid ? ctrl_held : '0;

  // Stall counter next-state: saturating count of held cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed, table-driven bench for id_ex_stage_reg (default widths plus a CNT_W=4 copy).
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, bubble, flush, out_ready;
  logic [1:0]  wb_in, m_in;
  logic [3:0]  ex_in;
  logic [31:0] r1_in, r2_in, sx_in;
  logic [4:0]  rs_in, rt_in, rd_in;

  logic        in_ready, out_valid;
  logic [1:0]  wb_out, m_out;
  logic [3:0]  ex_out;
  logic [31:0] r1_out, r2_out, sx_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic [15:0] stall_cnt;

  logic        in_ready4, out_valid4;
  logic [1:0]  wb_out4, m_out4;
  logic [3:0]  ex_out4;
  logic [31:0] r1_out4, r2_out4, sx_out4;
  logic [4:0]  rs_out4, rt_out4, rd_out4;
  logic [3:0]  stall_cnt4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .data_r1_in(r1_in), .data_r2_in(r2_in), .sign_ext_in(sx_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .bubble(bubble), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
    .data_r1_out(r1_out), .data_r2_out(r2_out), .sign_ext_out(sx_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .stall_cnt(stall_cnt)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .data_r1_in(r1_in), .data_r2_in(r2_in), .sign_ext_in(sx_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .bubble(bubble), .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
    .wb_out(wb_out4), .m_out(m_out4), .ex_out(ex_out4),
    .data_r1_out(r1_out4), .data_r2_out(r2_out4), .sign_ext_out(sx_out4),
    .rs_out(rs_out4), .rt_out(rt_out4), .rd_out(rd_out4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic        rst, iv, ordy, bub, fl;
    logic [1:0]  wb, m;
    logic [3:0]  ex;
    logic [31:0] r1;
    logic [4:0]  rd;
    logic        ov, ir;
    logic [1:0]  ewb, em;
    logic [3:0]  eex;
    logic [31:0] er1;
    logic [4:0]  erd;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic r, logic iv, logic ordy, logic bub, logic fl,
                              logic [1:0] wb, logic [1:0] m, logic [3:0] ex,
                              logic [31:0] r1, logic [4:0] rd,
                              logic ov, logic ir, logic [1:0] ewb, logic [1:0] em,
                              logic [3:0] eex, logic [31:0] er1, logic [4:0] erd,
                              logic [15:0] ecnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.ordy = ordy; v.bub = bub; v.fl = fl;
    v.wb = wb; v.m = m; v.ex = ex; v.r1 = r1; v.rd = rd;
    v.ov = ov; v.ir = ir; v.ewb = ewb; v.em = em; v.eex = eex;
    v.er1 = er1; v.erd = erd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Other operand fields are derived from r1 so every payload bit is traceable.
  task automatic drive(input logic r, input logic iv, input logic ordy, input logic bub,
                       input logic fl, input logic [1:0] wb, input logic [1:0] m,
                       input logic [3:0] ex, input logic [31:0] r1, input logic [4:0] rd);
    logic [31:0] t3;
    t3 = r1 * 3;
    rst = r; in_valid = iv; out_ready = ordy; bubble = bub; flush = fl;
    wb_in = wb; m_in = m; ex_in = ex; rd_in = rd;
    r1_in = r1; r2_in = t3; sx_in = r1 * 7; rs_in = r1[4:0]; rt_in = t3[4:0];
  endtask

  task automatic check_data(input string nm, input logic [31:0] er1, input logic [4:0] erd);
    logic [31:0] t3;
    t3 = er1 * 3;
    check(nm, {r1_out, r2_out, sx_out, rs_out, rt_out, rd_out},
          {er1, t3, er1 * 32'd7, er1[4:0], t3[4:0], erd});
  endtask

  initial begin
    //                rst iv rdy bb fl wb    m     ex    r1  rd  ov ir ewb   em    eex   er1 erd cnt
    vecs[0]  = mk(1, 1, 1, 0, 0, 2'd1, 2'd1, 4'd1, 9,  9,  0, 1, 2'd0, 2'd0, 4'h0, 0,  0,  0);
    vecs[1]  = mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0,  0,  0, 1, 2'd0, 2'd0, 4'h0, 0,  0,  0);
    vecs[2]  = mk(0, 1, 1, 0, 0, 2'd1, 2'd1, 4'd1, 1,  1,  1, 1, 2'd1, 2'd1, 4'h1, 1,  1,  0);
    vecs[3]  = mk(0, 1, 1, 0, 0, 2'd2, 2'd2, 4'd2, 2,  2,  1, 1, 2'd2, 2'd2, 4'h2, 2,  2,  0);
    vecs[4]  = mk(0, 1, 1, 0, 0, 2'd3, 2'd3, 4'd3, 3,  3,  1, 1, 2'd3, 2'd3, 4'h3, 3,  3,  0);
    vecs[5]  = mk(0, 1, 1, 0, 0, 2'd0, 2'd1, 4'd4, 4,  4,  1, 1, 2'd0, 2'd1, 4'h4, 4,  4,  0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0,  0,  0, 1, 2'd0, 2'd0, 4'h0, 4,  4,  0);
    // A into main, B into skid, C refused while skid full
    vecs[7]  = mk(0, 1, 0, 0, 0, 2'd1, 2'd2, 4'd5, 10, 10, 1, 1, 2'd1, 2'd2, 4'h5, 10, 10, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 2'd2, 2'd1, 4'd6, 11, 11, 1, 0, 2'd1, 2'd2, 4'h5, 10, 10, 1);
    vecs[9]  = mk(0, 1, 0, 0, 0, 2'd3, 2'd3, 4'd7, 12, 12, 1, 0, 2'd1, 2'd2, 4'h5, 10, 10, 2);
    vecs[10] = mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0,  0,  1, 1, 2'd2, 2'd1, 4'h6, 11, 11, 2);
    vecs[11] = mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0,  0,  0, 1, 2'd0, 2'd0, 4'h0, 11, 11, 2);
    // bubble
    vecs[12] = mk(0, 1, 1, 1, 0, 2'd3, 2'd2, 4'hF, 20, 9,  1, 1, 2'd0, 2'd0, 4'h0, 20, 9,  2);
    vecs[13] = mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0,  0,  0, 1, 2'd0, 2'd0, 4'h0, 20, 9,  2);
    // flush with both entries full; flushed input never appears
    vecs[14] = mk(0, 1, 0, 0, 0, 2'd1, 2'd1, 4'd1, 30, 3,  1, 1, 2'd1, 2'd1, 4'h1, 30, 3,  2);
    vecs[15] = mk(0, 1, 0, 0, 0, 2'd2, 2'd2, 4'd2, 31, 4,  1, 0, 2'd1, 2'd1, 4'h1, 30, 3,  3);
    vecs[16] = mk(0, 1, 0, 0, 1, 2'd3, 2'd3, 4'd3, 32, 5,  0, 1, 2'd0, 2'd0, 4'h0, 30, 3,  4);
    vecs[17] = mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0,  0,  0, 1, 2'd0, 2'd0, 4'h0, 30, 3,  4);
    // flush with deliver, bubble with flush
    vecs[18] = mk(0, 1, 1, 0, 0, 2'd1, 2'd1, 4'd1, 40, 6,  1, 1, 2'd1, 2'd1, 4'h1, 40, 6,  4);
    vecs[19] = mk(0, 1, 1, 1, 1, 2'd2, 2'd2, 4'd2, 41, 7,  0, 1, 2'd0, 2'd0, 4'h0, 40, 6,  4);
    // reset with both entries full
    vecs[20] = mk(0, 1, 0, 0, 0, 2'd1, 2'd1, 4'd3, 50, 7,  1, 1, 2'd1, 2'd1, 4'h3, 50, 7,  4);
    vecs[21] = mk(0, 1, 0, 0, 0, 2'd2, 2'd2, 4'd4, 51, 8,  1, 0, 2'd1, 2'd1, 4'h3, 50, 7,  5);
    vecs[22] = mk(1, 1, 0, 0, 0, 2'd3, 2'd3, 4'd5, 52, 9,  0, 1, 2'd0, 2'd0, 4'h0, 0,  0,  0);
    vecs[23] = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0,  0,  0, 1, 2'd0, 2'd0, 4'h0, 0,  0,  0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ordy, vecs[i].bub, vecs[i].fl,
            vecs[i].wb, vecs[i].m, vecs[i].ex, vecs[i].r1, vecs[i].rd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d hs", i), {out_valid, in_ready}, {vecs[i].ov, vecs[i].ir});
      check($sformatf("v%0d ctl", i), {wb_out, m_out, ex_out},
            {vecs[i].ewb, vecs[i].em, vecs[i].eex});
      check_data($sformatf("v%0d data", i), vecs[i].er1, vecs[i].erd);
      check($sformatf("v%0d cnt", i), {stall_cnt, stall_cnt4},
            {vecs[i].ecnt, vecs[i].ecnt[3:0]});
    end

    // Saturation: hold one entry for 20 cycles; the 4-bit counter sticks at 15.
    drive(0, 1, 0, 0, 0, 2'd1, 2'd1, 4'd1, 60, 12);
    @(posedge clk);
    #1;
    check("sat load", {out_valid, stall_cnt, stall_cnt4}, {1'b1, 16'd0, 4'd0});
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0);
      @(posedge clk);
      #1;
      check($sformatf("sat k%0d", k), {out_valid, stall_cnt, stall_cnt4},
            {1'b1, 16'(k), (k > 15) ? 4'd15 : 4'(k)});
    end
    check_data("sat data", 60, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
